// File: rtl/bus_demux.sv
// Address-decoding bus demultiplexer: routes one host port to N_TGT targets,
// tracks outstanding reads per owner and answers unmapped reads with ERR_DATA.
module bus_demux #(
  parameter int                     N_TGT     = 2,
  parameter int                     XLEN      = 32,
  parameter logic [N_TGT*XLEN-1:0]  TGT_BASE  = {32'h2000_0000, 32'h0000_0000},
  parameter logic [N_TGT*XLEN-1:0]  TGT_MASK  = {32'hF000_0000, 32'hE000_0000},
  parameter int                     MAX_OUTST = 4,
  parameter logic [XLEN-1:0]        ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_req,
  input  logic                   host_write,
  input  logic [XLEN/8-1:0]      host_wstrb,
  input  logic [XLEN-1:0]        host_addr,
  input  logic [XLEN-1:0]        host_wdata,
  output logic                   host_ready,
  output logic                   host_rvalid,
  output logic [XLEN-1:0]        host_rdata,
  output logic [N_TGT-1:0]       tgt_req,
  output logic                   tgt_write,
  output logic [XLEN/8-1:0]      tgt_wstrb,
  output logic [XLEN-1:0]        tgt_addr,
  output logic [XLEN-1:0]        tgt_wdata,
  input  logic [N_TGT-1:0]       tgt_ready,
  input  logic [N_TGT-1:0]       tgt_rvalid,
  input  logic [N_TGT*XLEN-1:0]  tgt_rdata,
  output logic                   dec_err,
  output logic [XLEN-1:0]        err_addr
);

  localparam int SW = $clog2(N_TGT + 1);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [SW-1:0] ERR_SLOT = SW'(N_TGT);

  logic [SW-1:0] slot;
  logic [SW-1:0] cur_tgt;
  logic [CW-1:0] outst_cnt;
  logic          err_pend;
  logic          unmapped;
  logic          pass;
  logic          accept;
  logic          rd_accept;
  logic          rvalid_sel;
  logic [XLEN-1:0] rdata_sel;

  assign tgt_write = host_write;
  assign tgt_wstrb = host_wstrb;
  assign tgt_addr  = host_addr;
  assign tgt_wdata = host_wdata;

  // Descending scan so the lowest matching index wins on overlapping windows.
  always_comb begin
    slot = ERR_SLOT;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if ((host_addr & TGT_MASK[i*XLEN +: XLEN]) == TGT_BASE[i*XLEN +: XLEN])
        slot = SW'(i);
    end
  end

  assign unmapped = (slot == ERR_SLOT);
  assign pass = (outst_cnt == '0) ||
                ((slot == cur_tgt) && (outst_cnt < CW'(MAX_OUTST)));

  always_comb begin
    host_ready = 1'b0;
    tgt_req    = '0;
    if (!rst && pass) begin
      if (unmapped) begin
        host_ready = 1'b1;
      end else begin
        for (int i = 0; i < N_TGT; i++) begin
          if (slot == SW'(i)) begin
            host_ready = tgt_ready[i];
            tgt_req[i] = host_req;
          end
        end
      end
    end
  end

  assign accept    = host_req && host_ready;
  assign rd_accept = accept && !host_write;
  assign dec_err   = accept && unmapped;

  // Only the current owner may answer; the error slot answers from err_pend.
  always_comb begin
    rvalid_sel = 1'b0;
    rdata_sel  = '0;
    if (cur_tgt == ERR_SLOT) begin
      rvalid_sel = err_pend;
      rdata_sel  = ERR_DATA;
    end
    for (int i = 0; i < N_TGT; i++) begin
      if (cur_tgt == SW'(i)) begin
        rvalid_sel = tgt_rvalid[i];
        rdata_sel  = tgt_rdata[i*XLEN +: XLEN];
      end
    end
  end

  assign host_rvalid = !rst && rvalid_sel && (outst_cnt != '0);
  assign host_rdata  = host_rvalid ? rdata_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_cnt <= '0;
      cur_tgt   <= '0;
      err_addr  <= '0;
      err_pend  <= 1'b0;
    end else begin
      err_pend <= rd_accept && unmapped;
      if (accept && unmapped)
        err_addr <= host_addr;
      if (rd_accept)
        cur_tgt <= slot;
      if (rd_accept && !host_rvalid)
        outst_cnt <= outst_cnt + CW'(1);
      else if (!rd_accept && host_rvalid)
        outst_cnt <= outst_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_bus_demux.sv
// Directed self-checking bench for bus_demux with the default two-target map.
module tb_bus_demux;

  logic        clk;
  logic        rst;
  logic        host_req;
  logic        host_write;
  logic [3:0]  host_wstrb;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ready;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [1:0]  tgt_req;
  logic        tgt_write;
  logic [3:0]  tgt_wstrb;
  logic [31:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [1:0]  tgt_ready;
  logic [1:0]  tgt_rvalid;
  logic [63:0] tgt_rdata;
  logic        dec_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  bus_demux dut (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .host_write (host_write),
    .host_wstrb (host_wstrb),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ready (host_ready),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .tgt_req    (tgt_req),
    .tgt_write  (tgt_write),
    .tgt_wstrb  (tgt_wstrb),
    .tgt_addr   (tgt_addr),
    .tgt_wdata  (tgt_wdata),
    .tgt_ready  (tgt_ready),
    .tgt_rvalid (tgt_rvalid),
    .tgt_rdata  (tgt_rdata),
    .dec_err    (dec_err),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [1:0] rdy, input logic [1:0] rv);
    host_req   = req;
    host_write = wr;
    host_addr  = addr;
    tgt_ready  = rdy;
    tgt_rvalid = rv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    host_wstrb = 4'hF;
    host_wdata = 32'hCAFE_0001;
    tgt_rdata  = '0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'b11, 2'b11);
    checkOutput("rst_ready", {31'd0, host_ready}, 32'd0);
    checkOutput("rst_tgt_req", {30'd0, tgt_req}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    checkOutput("rst_err_addr", err_addr, 32'd0);
    checkOutput("rst_dec_err", {31'd0, dec_err}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    rst = 1'b0;
    tick();

    // Single read to target 0
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'b01, 2'b00);
    checkOutput("rd0_tgt_req", {30'd0, tgt_req}, 32'h1);
    checkOutput("rd0_ready", {31'd0, host_ready}, 32'h1);
    tick();
    tgt_rdata[31:0] = 32'h0000_1234;
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b01, 2'b01);
    checkOutput("rd0_rvalid", {31'd0, host_rvalid}, 32'h1);
    checkOutput("rd0_rdata", host_rdata, 32'h0000_1234);
    checkOutput("rd0_cnt_busy", 32'(dut.outst_cnt), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    checkOutput("rd0_cnt_done", 32'(dut.outst_cnt), 32'd0);
    checkOutput("rd0_rdata_idle", host_rdata, 32'd0);

    // Write to target 1, then a stray rvalid with nothing outstanding
    applyStimulus(1'b1, 1'b1, 32'h2000_0004, 2'b10, 2'b00);
    checkOutput("wr1_tgt_req", {30'd0, tgt_req}, 32'h2);
    checkOutput("wr1_tgt_addr", tgt_addr, 32'h2000_0004);
    checkOutput("wr1_tgt_write", {31'd0, tgt_write}, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b10);
    checkOutput("wr1_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    checkOutput("wr1_cnt", 32'(dut.outst_cnt), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 2'b00, 2'b00);
    checkOutput("dec_1000_tgt_req", {30'd0, tgt_req}, 32'h1);
    checkOutput("dec_1000_ready", {31'd0, host_ready}, 32'd0);

    // Fill to MAX_OUTST, fifth read stalls until a response arrives
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fill_ready_%0d", i), {31'd0, host_ready}, 32'h1);
      tick();
    end
    checkOutput("fill_cnt", 32'(dut.outst_cnt), 32'd4);
    checkOutput("fifth_stall", {31'd0, host_ready}, 32'd0);
    checkOutput("fifth_no_req", {30'd0, tgt_req}, 32'd0);
    tick();
    tgt_rdata[31:0] = 32'h0000_AAAA;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'b01, 2'b01);
    checkOutput("fifth_resp_rvalid", {31'd0, host_rvalid}, 32'h1);
    checkOutput("fifth_resp_stall", {31'd0, host_ready}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'b01, 2'b00);
    checkOutput("fifth_accept", {31'd0, host_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b01);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    checkOutput("drain_cnt", 32'(dut.outst_cnt), 32'd0);

    // Target switch waits for target 0 to drain
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'b11, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 2'b11, 2'b00);
    checkOutput("sw_stall", {31'd0, host_ready}, 32'd0);
    checkOutput("sw_no_req", {30'd0, tgt_req}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 2'b11, 2'b01);
    checkOutput("sw_stall_resp", {31'd0, host_ready}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 2'b11, 2'b00);
    checkOutput("sw_accept", {31'd0, host_ready}, 32'h1);
    checkOutput("sw_tgt_req", {30'd0, tgt_req}, 32'h2);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b01);
    checkOutput("sw_other_ignored", {31'd0, host_rvalid}, 32'd0);
    tgt_rdata[63:32] = 32'h0000_5555;
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b10);
    checkOutput("sw_rdata1", host_rdata, 32'h0000_5555);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);

    // Unmapped read
    applyStimulus(1'b1, 1'b0, 32'h4000_0000, 2'b00, 2'b00);
    checkOutput("err_ready", {31'd0, host_ready}, 32'h1);
    checkOutput("err_dec_err", {31'd0, dec_err}, 32'h1);
    checkOutput("err_no_req", {30'd0, tgt_req}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    checkOutput("err_addr", err_addr, 32'h4000_0000);
    checkOutput("err_dec_err_low", {31'd0, dec_err}, 32'd0);
    checkOutput("err_rvalid", {31'd0, host_rvalid}, 32'h1);
    checkOutput("err_rdata", host_rdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("err_rvalid_low", {31'd0, host_rvalid}, 32'd0);

    // Back-to-back unmapped reads
    applyStimulus(1'b1, 1'b0, 32'h5000_0000, 2'b00, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h3000_0000, 2'b00, 2'b00);
    checkOutput("b2b_ready", {31'd0, host_ready}, 32'h1);
    checkOutput("b2b_rvalid_a", {31'd0, host_rvalid}, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    checkOutput("b2b_rvalid_b", {31'd0, host_rvalid}, 32'h1);
    checkOutput("b2b_err_addr", err_addr, 32'h3000_0000);
    tick();
    checkOutput("b2b_cnt", 32'(dut.outst_cnt), 32'd0);

    // Unmapped write is absorbed without a response
    applyStimulus(1'b1, 1'b1, 32'h6000_0000, 2'b11, 2'b00);
    checkOutput("errwr_dec_err", {31'd0, dec_err}, 32'h1);
    checkOutput("errwr_no_req", {30'd0, tgt_req}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    checkOutput("errwr_no_rvalid", {31'd0, host_rvalid}, 32'd0);

    // Reset with two reads outstanding
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'b01, 2'b00);
    tick();
    tick();
    checkOutput("mid_cnt", 32'(dut.outst_cnt), 32'd2);
    host_req = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_cnt", 32'(dut.outst_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tgt_rdata[31:0] = 32'h0000_7777;
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b01);
    checkOutput("post_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    checkOutput("post_rst_rdata", host_rdata, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    checkOutput("post_rst_cnt", 32'(dut.outst_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_demux.md
BUS_DEMUX -- requirements
Module: bus_demux

Interface
REQ-001 SHALL have parameter N_TGT, default 2, number of downstream targets (1..8).
REQ-002 SHALL have parameter XLEN, default 32, address/data width.
REQ-003 SHALL have parameter TGT_BASE, default {32'h2000_0000, 32'h0000_0000}, packed N_TGT*XLEN base addresses, index 0 in the LSBs.
REQ-004 SHALL have parameter TGT_MASK, default {32'hF000_0000, 32'hE000_0000}, packed N_TGT*XLEN decode masks.
REQ-005 SHALL have parameter MAX_OUTST, default 4, maximum outstanding reads (1..15).
REQ-006 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned for unmapped addresses.
REQ-007 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-008 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-009 SHALL have host ports host_req (in, 1), host_write (in, 1), host_wstrb (in, XLEN/8), host_addr (in, XLEN), host_wdata (in, XLEN): upstream request.
REQ-010 SHALL have host ports host_ready (out, 1), host_rvalid (out, 1), host_rdata (out, XLEN): upstream accept and read response.
REQ-011 SHALL have tgt_req (out, N_TGT), one-hot target request.
REQ-012 SHALL have tgt_write (out, 1), tgt_wstrb (out, XLEN/8), tgt_addr (out, XLEN), tgt_wdata (out, XLEN), broadcast to all targets.
REQ-013 SHALL have tgt_ready (in, N_TGT), tgt_rvalid (in, N_TGT), tgt_rdata (in, N_TGT*XLEN), per-target response.
REQ-014 SHALL have dec_err (out, 1), one-cycle pulse on an accepted unmapped request.
REQ-015 SHALL have err_addr (out, XLEN), address of the most recent unmapped request.

Function
REQ-016 SHALL decode target i when (host_addr & TGT_MASK[i]) == TGT_BASE[i]; the lowest index wins on overlap; no match means unmapped.
REQ-017 SHALL accept a request in a cycle with host_req & host_ready; an accepted read counts as outstanding, a write does not.
REQ-018 SHALL hold the owner register cur_tgt (0..N_TGT, where N_TGT means the error slot) and the counter outst_cnt (0..MAX_OUTST).
REQ-019 SHALL compute pass = (outst_cnt == 0) | (decoded slot == cur_tgt & outst_cnt < MAX_OUTST); a request failing pass SHALL stall with host_ready = 0 and all tgt_req = 0.
REQ-020 SHALL, for a mapped request with pass, drive tgt_req[i] = host_req combinationally and set host_ready = tgt_ready[i].
REQ-021 SHALL, for an unmapped request with pass, set host_ready = 1, assert no tgt_req, pulse dec_err, load err_addr, and drop any write.
REQ-022 SHALL return an accepted unmapped read exactly one cycle later with host_rvalid = 1 and host_rdata = ERR_DATA; back-to-back unmapped reads SHALL produce back-to-back responses.
REQ-023 SHALL, when a read is accepted, load cur_tgt with the decoded slot.
REQ-024 SHALL forward host_rvalid = tgt_rvalid[cur_tgt] & (outst_cnt != 0), with host_rdata = tgt_rdata[cur_tgt]; all other tgt_rvalid inputs and any rvalid while outst_cnt == 0 SHALL be ignored.
REQ-025 SHALL increment outst_cnt on a read accept, decrement it on a response, and leave it unchanged when both happen in the same cycle.
REQ-026 SHALL never let outst_cnt exceed MAX_OUTST or underflow.
REQ-027 SHALL have no added latency on mapped paths; the target's response cycle is the host response cycle.
REQ-028 SHALL drive host_rdata = 0 whenever host_rvalid = 0.

Reset
REQ-029 SHALL, while rst = 1, force outst_cnt = 0, cur_tgt = 0, err_addr = 0, the pending error response = 0, and dec_err = 0.
REQ-030 SHALL, during reset, drive host_ready = 0, host_rvalid = 0, and tgt_req = 0.
REQ-031 SHALL discard outstanding reads on reset asserted mid-transaction; later target rvalid SHALL be ignored until a new read is accepted.

Verification
REQ-032 Read 0x0000_0010, tgt_ready[0] = 1, tgt_rvalid[0] one cycle later with 0x1234 -> tgt_req = 2'b01, host_rvalid with 0x1234, outst_cnt back to 0.
REQ-033 Write 0x2000_0004 -> tgt_req = 2'b10; no host_rvalid; outst_cnt stays 0.
REQ-034 Four reads to target 0 with rvalid withheld, then a fifth read -> host_ready = 0 on the fifth until one response arrives.
REQ-035 A read to target 0 outstanding, then a read to 0x2000_0000 -> stalled until target 0 responds; accepted the cycle outst_cnt reaches 0.
REQ-036 Read 0x4000_0000 -> host_ready = 1, dec_err pulse, err_addr = 0x4000_0000, next cycle host_rvalid with 0xDEAD_BEEF.
REQ-037 rst pulsed with 2 reads outstanding, then target rvalid -> host_rvalid stays 0, outst_cnt = 0.
